// File: rtl/col_pkg.sv
// Shared types and constants for the column-counter display path.
// Used by both the button-side stepper and the counter it drives.
package col_pkg;

    localparam int LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        DONE
    } state_t;

    // Shorter way round the 3-bit ring; a tie (distance 4) goes up.
    function automatic logic pick_up(input level_t cur, input level_t tgt);
        level_t up_dist;
        level_t dn_dist;
        up_dist = tgt - cur;
        dn_dist = cur - tgt;
        return (up_dist <= dn_dist);
    endfunction

endpackage

// File: rtl/col_counter.sv
// Column counter: steps a 3-bit wrapping value on each falling edge of the
// active-low up/down buttons, after a 2-FF synchroniser. Both at once cancel.
module col_counter
    import col_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   but_up_n,
    input  logic   but_dn_n,
    output level_t value
);

    // [1:0] synchronise, [2] holds the previous synchronised sample
    logic [2:0] up_s;
    logic [2:0] dn_s;
    logic       up_fall;
    logic       dn_fall;

    assign up_fall = up_s[2] & ~up_s[1];
    assign dn_fall = dn_s[2] & ~dn_s[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            up_s  <= 3'b111;
            dn_s  <= 3'b111;
            value <= '0;
        end else begin
            up_s <= {up_s[1:0], but_up_n};
            dn_s <= {dn_s[1:0], but_dn_n};
            if (up_fall && !dn_fall) begin
                value <= (value == LEVEL_MAX) ? '0 : value + 3'd1;
            end else if (dn_fall && !up_fall) begin
                value <= (value == '0) ? LEVEL_MAX : value - 3'd1;
            end
        end
    end

endmodule

// File: rtl/col_stepper.sv
// Drives active-low up/down button presses until a downstream col_counter
// reaches the requested level; keeps a shadow copy of that level.
module col_stepper
    import col_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEVEL_W-1:0] target,
    output logic               but_up_n,
    output logic               but_dn_n,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PRESS_LD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

    state_t        state;
    level_t        tgt;
    logic          dir_up;
    logic [TW-1:0] timer;
    logic          start_up;

    assign start_up = pick_up(level, target);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            but_up_n <= 1'b1;
            but_dn_n <= 1'b1;
            level    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tgt      <= '0;
            dir_up   <= 1'b1;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tgt    <= target;
                        dir_up <= start_up;
                        busy   <= 1'b1;
                        if (target != level) begin
                            state    <= PRESS;
                            timer    <= PRESS_LD;
                            but_up_n <= ~start_up;
                            but_dn_n <= start_up;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (timer == '0) begin
                        but_up_n <= 1'b1;
                        but_dn_n <= 1'b1;
                        level    <= dir_up ? level + 3'd1 : level - 3'd1;
                        timer    <= GAP_LD;
                        state    <= GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        if (level == tgt) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= PRESS;
                            timer    <= PRESS_LD;
                            but_up_n <= ~dir_up;
                            but_dn_n <= dir_up;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_col_stepper.sv
// Bench for col_stepper driving a col_counter; expected completions are queued
// at start time and checked by an independent monitor when done pulses.
module tb_col_stepper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] target = 3'd0;
    logic       but_up_n;
    logic       but_dn_n;
    logic [2:0] level;
    logic       busy;
    logic       done;
    logic [2:0] cnt_value;

    col_stepper #(.PRESS_CYCLES(4), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .but_up_n(but_up_n), .but_dn_n(but_dn_n), .level(level),
        .busy(busy), .done(done)
    );

    col_counter rx (
        .clk(clk), .reset(reset), .but_up_n(but_up_n), .but_dn_n(but_dn_n),
        .value(cnt_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] lvl;
        int         done_cyc;
        int         ups;
        int         dns;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Cycle k is the cycle that ends at rising edge k; start is sampled at E0 = cyc+1.
    task automatic issue(input logic [2:0] t, input logic [2:0] lvl, input int n_up, input int n_dn);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        target = t;
        e.lvl      = lvl;
        e.done_cyc = cyc + 1 + (n_up + n_dn) * 8 + 1;
        e.ups      = n_up;
        e.dns      = n_dn;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check({name, "_completed"}, (sb.size() == 0) ? 1 : 0, 1);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: press shape, mutual exclusion, and scoreboard pop on done.
    exp_t me;
    logic prev_up = 1'b1;
    logic prev_dn = 1'b1;
    int   run_up = 0, run_dn = 0, cnt_up = 0, cnt_dn = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            run_up = 0; run_dn = 0; cnt_up = 0; cnt_dn = 0;
        end else begin
            if (!but_up_n && !but_dn_n) begin
                n_cmp++; n_err++;
                $display("FAIL both_low: up_n=%b dn_n=%b (cycle %0d)", but_up_n, but_dn_n, cyc);
            end
            if (prev_up && !but_up_n) cnt_up++;
            if (prev_dn && !but_dn_n) cnt_dn++;
            if (!but_up_n) run_up++;
            if (!but_dn_n) run_dn++;
            if (!prev_up && but_up_n) begin
                check("up_press_width", run_up, 4);
                check("level_vs_counter_after_up", int'(level), int'(cnt_value));
                run_up = 0;
            end
            if (!prev_dn && but_dn_n) begin
                check("dn_press_width", run_dn, 4);
                check("level_vs_counter_after_dn", int'(level), int'(cnt_value));
                run_dn = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check("done_level", int'(level), int'(me.lvl));
                    check("done_counter", int'(cnt_value), int'(me.lvl));
                    check("done_cycle", cyc + 1, me.done_cyc);
                    check("up_presses", cnt_up, me.ups);
                    check("dn_presses", cnt_dn, me.dns);
                end
                cnt_up = 0;
                cnt_dn = 0;
            end
        end
        prev_up = but_up_n;
        prev_dn = but_dn_n;
    end

    initial begin
        repeat (10) @(negedge clk);
        check("rst_but_up_n", int'(but_up_n), 1);
        check("rst_but_dn_n", int'(but_dn_n), 1);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(3'd3, 3'd3, 3, 0); wait_idle("up_0_to_3");
        issue(3'd1, 3'd1, 0, 2); wait_idle("dn_3_to_1");
        issue(3'd6, 3'd6, 0, 3); wait_idle("dn_wrap_1_to_6");
        issue(3'd2, 3'd2, 4, 0); wait_idle("tie_6_to_2");
        issue(3'd2, 3'd2, 0, 0); wait_idle("same_level");

        // Second start while busy must not re-latch the target.
        issue(3'd4, 3'd4, 2, 0);
        repeat (4) @(negedge clk);
        check("busy_during_op", int'(busy), 1);
        start  = 1'b1;
        target = 3'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start_busy");

        // Reset during the second cycle of a press.
        @(negedge clk);
        start  = 1'b1;
        target = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_press_up_low", int'(but_up_n), 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_but_up_n", int'(but_up_n), 1);
        check("midrst_but_dn_n", int'(but_dn_n), 1);
        check("midrst_level", int'(level), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_counter", int'(cnt_value), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_level", int'(level), 0);
        check("post_rst_done", int'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
